// File: rtl/hist_peak_scan.sv
// Histogram band reader: sweeps bins LO_BIN..HI_BIN and reports the peak bin, peak magnitude and band sum,
// plus a hysteresis hit pulse. Optional macro HIST_SCAN_AUTORUN_EN makes the block re-sweep continuously.
module hist_peak_scan #(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 10,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned LO_BIN = 2,
  parameter int unsigned HI_BIN = 63,
  parameter int unsigned THRESH = 2000
) (
  input  logic          clock_27mhz,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] peak_bin,
  output logic [DW-1:0] peak_mag,
  output logic [19:0]   band_sum,
  output logic          hit
);

  localparam int unsigned SW = 20;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t          state, state_next;
  logic [RD_LAT-1:0] vpipe;
  logic [AW-1:0]   bpipe [RD_LAT];
  logic [SW-1:0]   wsum;
  logic [DW-1:0]   wmag;
  logic [AW-1:0]   wbin;
  logic            armed;
  logic            go, accept, issue, last, finish, busy_next;

`ifdef HIST_SCAN_AUTORUN_EN
  logic running;
  assign go = start | running;
`else
  assign go = start;
`endif

  assign last = (raddr == AW'(HI_BIN));

  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_next = SCAN;
        accept     = 1'b1;
      end
      SCAN: begin
        issue = 1'b1;
        if (last) state_next = DRAIN;
      end
      DRAIN: if (vpipe == '0) begin
        state_next = FINISH;
        finish     = 1'b1;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef HIST_SCAN_AUTORUN_EN
    busy_next = (state_next != IDLE);
`else
    busy_next = (state_next == SCAN) || (state_next == DRAIN);
`endif
  end

  // Read pipeline, accumulators and registered results; results publish on entry to FINISH.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      raddr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      peak_bin <= '0;
      peak_mag <= '0;
      band_sum <= '0;
      hit      <= 1'b0;
      armed    <= 1'b1;
      wsum     <= '0;
      wmag     <= '0;
      wbin     <= '0;
      vpipe    <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) bpipe[i] <= '0;
`ifdef HIST_SCAN_AUTORUN_EN
      running  <= 1'b0;
`endif
    end else begin
      busy <= busy_next;
      done <= finish;
      hit  <= 1'b0;

      vpipe[0] <= issue;
      bpipe[0] <= raddr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        bpipe[i] <= bpipe[i-1];
      end

      if (issue && !last) raddr <= raddr + AW'(1);
      else                raddr <= AW'(LO_BIN);

      if (accept) begin
        wsum <= '0;
        wmag <= '0;
        wbin <= AW'(LO_BIN);
      end else if (vpipe[RD_LAT-1]) begin
        wsum <= wsum + SW'(rdata);
        // Strict compare keeps the lowest bin on ties.
        if (rdata > wmag) begin
          wmag <= rdata;
          wbin <= bpipe[RD_LAT-1];
        end
      end

      if (finish) begin
        band_sum <= wsum;
        peak_mag <= wmag;
        peak_bin <= wbin;
        if (armed && (wsum >= SW'(THRESH))) begin
          hit   <= 1'b1;
          armed <= 1'b0;
        end else if (!armed && (wsum < SW'(THRESH >> 1))) begin
          armed <= 1'b1;
        end
      end

`ifdef HIST_SCAN_AUTORUN_EN
      if (accept) running <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_hist_peak_scan.sv
// Scoreboard bench for hist_peak_scan: three instances (RD_LAT 1, 2, 4) share one RAM image and stimulus;
// expected results are queued at start and popped by a per-instance monitor on done.
module tb_hist_peak_scan;

  typedef struct {
    logic [9:0]  bin;
    logic [9:0]  mag;
    logic [19:0] sum;
    logic        hit;
    int          start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] mem [1024];
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event not expected / not seen (t=%0t)", name, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [9:0]  raddr, rdata, peak_bin, peak_mag;
    logic [19:0] band_sum;
    logic        busy, done, hit;
    logic [9:0]  apipe [LAT];
    exp_t        expq [$];

    hist_peak_scan #(.RD_LAT(LAT)) dut (
      .clock_27mhz(clk), .reset(rst), .start(start), .raddr(raddr), .rdata(rdata),
      .busy(busy), .done(done), .peak_bin(peak_bin), .peak_mag(peak_mag),
      .band_sum(band_sum), .hit(hit)
    );

    // RAM model with LAT cycles of read latency.
    always @(posedge clk) begin
      apipe[0] <= raddr;
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign rdata = mem[apipe[LAT-1]];

    always @(negedge clk) begin
      if (done) begin
        if (expq.size() == 0) begin
          fail_now($sformatf("unexpected_done_lat%0d", LAT));
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk($sformatf("latency_lat%0d", LAT), 32'(cyc - e.start_cyc), 32'(64 + LAT));
          chk($sformatf("peak_bin_lat%0d", LAT), 32'(peak_bin), 32'(e.bin));
          chk($sformatf("peak_mag_lat%0d", LAT), 32'(peak_mag), 32'(e.mag));
          chk($sformatf("band_sum_lat%0d", LAT), 32'(band_sum), 32'(e.sum));
          chk($sformatf("hit_lat%0d", LAT), 32'(hit), 32'(e.hit));
          chk($sformatf("busy_at_done_lat%0d", LAT), 32'(busy), 32'(0));
        end
      end else if (hit) begin
        fail_now($sformatf("hit_without_done_lat%0d", LAT));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 10'd0;
  endtask

  task automatic ramp_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 10'(i);
    mem[1]  = 10'd1000;
    mem[64] = 10'd1000;
  endtask

  task automatic push_all(input exp_t e);
    lane[0].expq.push_back(e);
    lane[1].expq.push_back(e);
    lane[2].expq.push_back(e);
  endtask

  task automatic pulse_start(input bit expect_sweep, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    e.start_cyc = cyc;
    if (expect_sweep) push_all(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((lane[0].expq.size() + lane[1].expq.size() + lane[2].expq.size()) != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");
    repeat (3) @(negedge clk);
    chk("idle_busy_lat1", 32'(lane[0].busy), 32'(0));
    chk("idle_busy_lat4", 32'(lane[2].busy), 32'(0));
  endtask

  task automatic sweep(input logic [9:0] b, input logic [9:0] m, input logic [19:0] s, input logic h);
    exp_t e;
    e.bin = b; e.mag = m; e.sum = s; e.hit = h; e.start_cyc = 0;
    pulse_start(1'b1, e);
    wait_drain();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_raddr"},    32'(lane[1].raddr),    32'(0));
    chk({tag, "_busy"},     32'(lane[1].busy),     32'(0));
    chk({tag, "_done"},     32'(lane[1].done),     32'(0));
    chk({tag, "_peak_bin"}, 32'(lane[1].peak_bin), 32'(0));
    chk({tag, "_peak_mag"}, 32'(lane[1].peak_mag), 32'(0));
    chk({tag, "_band_sum"}, 32'(lane[2].band_sum), 32'(0));
    chk({tag, "_hit"},      32'(lane[0].hit),      32'(0));
  endtask

  initial begin
    exp_t e;
    rst   = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_raddr", 32'(lane[1].raddr), 32'(2));

    // Ramp sweep with raddr sequence check on the RD_LAT=2 instance.
    ramp_mem();
    e.bin = 10'd63; e.mag = 10'd63; e.sum = 20'd2015; e.hit = 1'b1; e.start_cyc = 0;
    pulse_start(1'b1, e);
    for (int k = 0; k < 62; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("raddr_%0d", 2 + k), 32'(lane[1].raddr), 32'(2 + k));
    end
    wait_drain();

    // Tie: lowest bin wins.
    clear_mem();
    mem[10] = 10'd900; mem[40] = 10'd900;
    sweep(10'd10, 10'd900, 20'd1800, 1'b0);

    // All-zero band re-arms.
    clear_mem();
    sweep(10'd2, 10'd0, 20'd0, 1'b0);

    // Hysteresis 2100, 2100, 900, 2100.
    clear_mem();
    mem[20] = 10'd1000; mem[30] = 10'd1000; mem[50] = 10'd100;
    sweep(10'd20, 10'd1000, 20'd2100, 1'b1);
    sweep(10'd20, 10'd1000, 20'd2100, 1'b0);
    clear_mem();
    mem[5] = 10'd900;
    sweep(10'd5, 10'd900, 20'd900, 1'b0);
    clear_mem();
    mem[20] = 10'd1000; mem[30] = 10'd1000; mem[50] = 10'd100;
    sweep(10'd20, 10'd1000, 20'd2100, 1'b1);

    // Threshold boundaries: 1000 does not re-arm, 999 does, 2000 exactly fires.
    clear_mem();
    mem[2] = 10'd1000; mem[1] = 10'd1023;
    sweep(10'd2, 10'd1000, 20'd1000, 1'b0);
    clear_mem();
    mem[62] = 10'd1000; mem[63] = 10'd1000; mem[64] = 10'd1023;
    sweep(10'd62, 10'd1000, 20'd2000, 1'b0);
    clear_mem();
    mem[63] = 10'd999;
    sweep(10'd63, 10'd999, 20'd999, 1'b0);
    clear_mem();
    mem[62] = 10'd1000; mem[63] = 10'd1000;
    sweep(10'd62, 10'd1000, 20'd2000, 1'b1);

    // Second start while busy is ignored: exactly one done.
    e.bin = 10'd62; e.mag = 10'd1000; e.sum = 20'd2000; e.hit = 1'b0; e.start_cyc = 0;
    pulse_start(1'b1, e);
    repeat (3) @(negedge clk);
    pulse_start(1'b0, e);
    wait_drain();
    repeat (80) @(negedge clk);
    chk("no_second_sweep_busy", 32'(lane[1].busy), 32'(0));

    // Reset 20 cycles into a sweep discards it; next sweep is complete and armed.
    ramp_mem();
    pulse_start(1'b0, e);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    sweep(10'd63, 10'd63, 20'd2015, 1'b1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
